xvar_deserializer: RTL and testbench
====================================

# xvar_deserializer

- Downstream consumer of the two-state a/b selector FSM.
- Samples that FSM's single-bit output `x_var` on a qualifying strobe and assembles `WIDTH` consecutive bits into a parallel word.
- Presents each word on a one-entry valid/ready output buffer.
- Flags any completed word lost because the consumer stalled.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = first sampled bit lands in `word_out[WIDTH-1]`; 0 = first bit lands in `word_out[0]`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  serial data; connected to upstream `x_var`.
- `bit_en`  in  1  sample strobe; `bit_in` is captured only when high.
- `frame_start`  in  1  start or restart a frame; discards any partial word.
- `frame_stop`  in  1  end the frame; discards any partial word and returns to IDLE.
- `word_out`  out  WIDTH  assembled word.
- `word_valid`  out  1  `word_out` holds an unconsumed word.
- `word_ready`  in  1  consumer accepts the word when high with `word_valid`.
- `busy`  out  1  high while in COLLECT.
- `bit_count`  out  $clog2(WIDTH)  bits captured so far in the current word.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.

## Operation
- Reset values (async, immediate): state IDLE; shift register, `bit_count` and `word_out` all 0; `word_valid`, `busy` and `overrun` all 0.
- State machine:
  - IDLE: `bit_en` ignored. `frame_start` → COLLECT with count 0.
  - COLLECT: each `bit_en` shifts `bit_in` in and increments count.
  - COLLECT, `frame_start`: count cleared, partial word discarded, state unchanged.
  - COLLECT, `frame_stop`: go to IDLE; partial word discarded.
- Priority when `frame_stop` and `frame_start` coincide: `frame_stop` wins; next state is IDLE.
- `frame_start` with `bit_en` in the same cycle: that bit is captured as bit 0 of the new word, in both IDLE and COLLECT.
- Word completion: `bit_en` arrives while count = WIDTH-1.
  - Count wraps to 0 and the state stays COLLECT, so frames stream continuously.
  - Buffer empty, or `word_valid & word_ready` in the same cycle: word loaded into `word_out`, `word_valid` = 1.
  - Buffer holding an unaccepted word: new word dropped, `overrun` pulses for one cycle, and the held `word_out` is unchanged.
- Output handshake:
  - Transfer occurs on `word_valid & word_ready`.
  - `word_out` is stable while `word_valid & !word_ready`.
  - `word_valid` falls the cycle after a transfer unless a new word loads in the same cycle.
- `frame_stop` and `frame_start` never clear the output buffer; a held word survives both.
- Bit ordering:
  - MSB_FIRST=1: shift left, new bit enters at position 0; after WIDTH bits, first bit sits at position WIDTH-1.
  - MSB_FIRST=0: shift right, new bit enters at position WIDTH-1; after WIDTH bits, first bit sits at position 0.

## Timing
- Capture latency: `word_valid` rises the cycle after the `bit_en` carrying the last bit.
- `overrun` asserts in that same cycle when the word is dropped.
- `bit_count` and `busy` are registered; they update the cycle after the causing input.
- Sustained throughput: one word per WIDTH strobes with no bubbles, provided `word_ready` is high at each completion.
- Inputs are synchronous to `clk`; upstream guarantees `bit_in` is settled whenever `bit_en` is high.
- No combinational path from `word_ready` to `word_valid` or `word_out`.
- Reset asserted mid-frame: all state cleared immediately; any held word is lost.

## Structure
- Shared package `foy_pkg` holds:
  - state typedef `deser_state_t` {IDLE, COLLECT};
  - default `WIDTH` constant;
  - a count-width function.
- One sub-module: `deser_out_buf`, the one-entry valid/ready holding register with load/accept/drop logic and the `overrun` pulse. Top level holds the FSM, shift register and counter.

## Test plan
- Reset, then `frame_start`; 8 strobes with bits 1,0,1,1,0,0,1,0 and `word_ready`=1, MSB_FIRST=1 → `word_out`=8'hB2, `word_valid` high one cycle.
- Same bits with MSB_FIRST=0 → `word_out`=8'h4D.
- Hold `word_ready`=0:
  - stream two words, A5 then 3C → `word_out` stays A5, `overrun` pulses once at the second completion;
  - then raise `word_ready` → A5 accepted and `word_valid` drops.
- 5 strobes, then `frame_start` together with `bit_en` carrying 1 → `bit_count`=1; the next word's first bit is 1; the partial word never appears.
- `frame_stop` after 3 bits → IDLE, `busy`=0; further `bit_en` is ignored and `bit_count` stays 0.
- Reset asserted mid-word with `word_valid`=1 → all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/foy_pkg.sv
// Shared definitions for the x_var deserializer: FSM state type, default
// word width and the bit-counter width helper.
package foy_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } deser_state_t;

   localparam int DESER_WIDTH_DEF = 8;

   // Counter width for a word of 'width' bits; never narrower than one bit.
   function automatic int deser_cnt_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for assembled words. A word that
// completes while an unaccepted word is held is dropped and flagged.
module deser_out_buf
   import foy_pkg::*;
#(
   parameter int WIDTH = DESER_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_word,
   output logic             o_valid,
   output logic             o_overrun
);

   logic [WIDTH-1:0] r_word;
   logic             r_valid;
   logic             r_overrun;
   logic [WIDTH-1:0] w_word_nxt;
   logic             w_valid_nxt;
   logic             w_overrun_nxt;
   logic             w_space;

   // Slot is free when empty or when the held word leaves this cycle.
   assign w_space = !r_valid || i_ready;

   // Load / drop / accept decision for the holding register.
   always_comb begin
      w_word_nxt    = r_word;
      w_valid_nxt   = r_valid;
      w_overrun_nxt = 1'b0;
      if (i_load) begin
         if (w_space) begin
            w_word_nxt  = i_word;
            w_valid_nxt = 1'b1;
         end else begin
            w_overrun_nxt = 1'b1;
         end
      end else if (r_valid && i_ready) begin
         w_valid_nxt = 1'b0;
      end else begin
         w_valid_nxt = r_valid;
      end
   end

   // Holding register state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_word    <= {WIDTH{1'b0}};
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_word    <= w_word_nxt;
         r_valid   <= w_valid_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   assign o_word    = r_word;
   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/xvar_deserializer.sv
// Samples the a/b selector's x_var on bit_en strobes and assembles WIDTH-bit
// words, handing each completed word to a one-entry valid/ready buffer.
module xvar_deserializer
   import foy_pkg::*;
#(
   parameter int  WIDTH     = DESER_WIDTH_DEF,
   parameter bit  MSB_FIRST = 1'b1,
   localparam int CW        = deser_cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_en,
   input  logic             frame_start,
   input  logic             frame_stop,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic [CW-1:0]    bit_count,
   output logic             overrun
);

   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   deser_state_t     r_state;
   deser_state_t     w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;
   logic             r_busy;
   logic             w_word_done;
   logic [WIDTH-1:0] w_shift_cur;
   logic [WIDTH-1:0] w_shift_new;

   // w_shift_cur continues the current word; w_shift_new starts a fresh one.
   generate
      if (MSB_FIRST) begin : g_msb
         assign w_shift_cur = {r_shift[WIDTH-2:0], bit_in};
         assign w_shift_new = {{(WIDTH-1){1'b0}}, bit_in};
      end else begin : g_lsb
         assign w_shift_cur = {bit_in, r_shift[WIDTH-1:1]};
         assign w_shift_new = {bit_in, {(WIDTH-1){1'b0}}};
      end
   endgenerate

   // Next-state, shift and count logic; frame_stop outranks frame_start.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_count_nxt = r_count;
      w_word_done = 1'b0;
      if (frame_stop) begin
         w_state_nxt = IDLE;
         w_shift_nxt = {WIDTH{1'b0}};
         w_count_nxt = {CW{1'b0}};
      end else if (frame_start) begin
         w_state_nxt = COLLECT;
         if (bit_en) begin
            w_shift_nxt = w_shift_new;
            w_count_nxt = CW'(1);
         end else begin
            w_shift_nxt = {WIDTH{1'b0}};
            w_count_nxt = {CW{1'b0}};
         end
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = IDLE;
            end
            COLLECT: begin
               if (bit_en) begin
                  if (r_count == LAST_CNT) begin
                     w_word_done = 1'b1;
                     w_shift_nxt = {WIDTH{1'b0}};
                     w_count_nxt = {CW{1'b0}};
                  end else begin
                     w_shift_nxt = w_shift_cur;
                     w_count_nxt = r_count + CW'(1);
                  end
               end else begin
                  w_state_nxt = COLLECT;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_shift_nxt = {WIDTH{1'b0}};
               w_count_nxt = {CW{1'b0}};
            end
         endcase
      end
   end

   // FSM, shift register and bit counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_shift <= {WIDTH{1'b0}};
         r_count <= {CW{1'b0}};
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_count <= w_count_nxt;
         r_busy  <= (w_state_nxt == COLLECT);
      end
   end

   assign busy      = r_busy;
   assign bit_count = r_count;

   deser_out_buf #(
      .WIDTH (WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_word_done),
      .i_word    (w_shift_cur),
      .i_ready   (word_ready),
      .o_word    (word_out),
      .o_valid   (word_valid),
      .o_overrun (overrun)
   );

endmodule

// File: tb/tb_xvar_deserializer.sv
// Directed vector bench: one MSB-first and one LSB-first instance share the
// same stimulus; each vector lists the outputs expected after its clock edge.
module tb_xvar_deserializer;

   logic       clk;
   logic       reset;
   logic       bit_in;
   logic       bit_en;
   logic       frame_start;
   logic       frame_stop;
   logic       word_ready;

   logic [7:0] word_out_m;
   logic       word_valid_m;
   logic       busy_m;
   logic [2:0] bit_count_m;
   logic       overrun_m;
   logic [7:0] word_out_l;
   logic       word_valid_l;
   logic       busy_l;
   logic [2:0] bit_count_l;
   logic       overrun_l;

   int n_vec;
   int n_bad;

   typedef struct {
      logic       en;
      logic       din;
      logic       st;
      logic       sp;
      logic       rdy;
      logic       ev;
      logic [7:0] ew;
      logic [7:0] ewl;
      logic [2:0] ec;
      logic       eb;
      logic       eo;
   } vec_t;

   vec_t vecs[$];

   xvar_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en),
      .frame_start(frame_start), .frame_stop(frame_stop),
      .word_out(word_out_m), .word_valid(word_valid_m), .word_ready(word_ready),
      .busy(busy_m), .bit_count(bit_count_m), .overrun(overrun_m)
   );

   xvar_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .bit_in(bit_in), .bit_en(bit_en),
      .frame_start(frame_start), .frame_stop(frame_stop),
      .word_out(word_out_l), .word_valid(word_valid_l), .word_ready(word_ready),
      .busy(busy_l), .bit_count(bit_count_l), .overrun(overrun_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(input int en, input int din, input int st,
                               input int sp, input int rdy, input int ev,
                               input int ew, input int ewl, input int ec,
                               input int eb, input int eo);
      vec_t v;
      v.en  = (en != 0);
      v.din = (din != 0);
      v.st  = (st != 0);
      v.sp  = (sp != 0);
      v.rdy = (rdy != 0);
      v.ev  = (ev != 0);
      v.ew  = 8'(ew);
      v.ewl = 8'(ewl);
      v.ec  = 3'(ec);
      v.eb  = (eb != 0);
      v.eo  = (eo != 0);
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic ev, input logic [7:0] ew,
                        input logic [7:0] ewl, input logic [2:0] ec,
                        input logic eb, input logic eo);
      n_vec++;
      if (word_valid_m !== ev || word_valid_l !== ev || word_out_m !== ew ||
          word_out_l !== ewl || bit_count_m !== ec || bit_count_l !== ec ||
          busy_m !== eb || busy_l !== eb || overrun_m !== eo || overrun_l !== eo) begin
         n_bad++;
         $display("FAIL %s: got valid=%b/%b word=%h/%h cnt=%0d/%0d busy=%b/%b ovr=%b/%b; want valid=%b word=%h/%h cnt=%0d busy=%b ovr=%b",
                  name, word_valid_m, word_valid_l, word_out_m, word_out_l,
                  bit_count_m, bit_count_l, busy_m, busy_l, overrun_m, overrun_l,
                  ev, ew, ewl, ec, eb, eo);
      end
   endtask

   task automatic drive(input logic en, input logic din, input logic st,
                        input logic sp, input logic rdy);
      bit_en      = en;
      bit_in      = din;
      frame_start = st;
      frame_stop  = sp;
      word_ready  = rdy;
   endtask

   task automatic add_bits(input logic [7:0] bits, input int rdy,
                           input int ev, input int ew, input int ewl);
      for (int k = 7; k >= 0; k--) begin
         add(1, int'(bits[k]), 0, 0, rdy, ev, ew, ewl, (8 - k) % 8, 1, 0);
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // en din st sp rdy | valid word wordl cnt busy ovr
      add(0,0,0,0,0, 0,8'h00,8'h00,0,0,0);
      add(0,0,1,0,1, 0,8'h00,8'h00,0,1,0);
      add(1,1,0,0,1, 0,8'h00,8'h00,1,1,0);
      add(1,0,0,0,1, 0,8'h00,8'h00,2,1,0);
      add(1,1,0,0,1, 0,8'h00,8'h00,3,1,0);
      add(1,1,0,0,1, 0,8'h00,8'h00,4,1,0);
      add(1,0,0,0,1, 0,8'h00,8'h00,5,1,0);
      add(1,0,0,0,1, 0,8'h00,8'h00,6,1,0);
      add(1,1,0,0,1, 0,8'h00,8'h00,7,1,0);
      add(1,0,0,0,1, 1,8'hB2,8'h4D,0,1,0);
      add(0,0,0,0,1, 0,8'hB2,8'h4D,0,1,0);
      // stalled consumer: A5 held, 3C dropped (both palindromes, same in LSB order)
      add_bits(8'hA5, 0, 0, 8'hB2, 8'h4D);
      vecs[$].ev = 1'b1; vecs[$].ew = 8'hA5; vecs[$].ewl = 8'hA5;
      add_bits(8'h3C, 0, 1, 8'hA5, 8'hA5);
      vecs[$].eo = 1'b1;
      add(0,0,0,0,0, 1,8'hA5,8'hA5,0,1,0);
      add(0,0,0,0,1, 0,8'hA5,8'hA5,0,1,0);
      // 5 bits, then restart carrying a 1
      for (int k = 1; k <= 5; k++) add(1,1,0,0,1, 0,8'hA5,8'hA5,k,1,0);
      add(1,1,1,0,1, 0,8'hA5,8'hA5,1,1,0);
      add(1,0,0,0,1, 0,8'hA5,8'hA5,2,1,0);
      add(1,0,0,0,1, 0,8'hA5,8'hA5,3,1,0);
      add(1,0,0,0,1, 0,8'hA5,8'hA5,4,1,0);
      add(1,0,0,0,1, 0,8'hA5,8'hA5,5,1,0);
      add(1,1,0,0,1, 0,8'hA5,8'hA5,6,1,0);
      add(1,1,0,0,1, 0,8'hA5,8'hA5,7,1,0);
      add(1,0,0,0,1, 1,8'h86,8'h61,0,1,0);
      add(0,0,0,0,1, 0,8'h86,8'h61,0,1,0);
      // stop after 3 bits, then strobes ignored in IDLE
      for (int k = 1; k <= 3; k++) add(1,1,0,0,1, 0,8'h86,8'h61,k,1,0);
      add(0,0,0,1,1, 0,8'h86,8'h61,0,0,0);
      add(1,1,0,0,1, 0,8'h86,8'h61,0,0,0);
      add(1,0,0,0,1, 0,8'h86,8'h61,0,0,0);
      add(1,1,1,1,1, 0,8'h86,8'h61,0,0,0);
      // start+bit in IDLE, held word survives stop and start+stop
      add(1,0,1,0,0, 0,8'h86,8'h61,1,1,0);
      for (int k = 2; k <= 7; k++) add(1,1,0,0,0, 0,8'h86,8'h61,k,1,0);
      add(1,1,0,0,0, 1,8'h7F,8'hFE,0,1,0);
      add(0,0,0,1,0, 1,8'h7F,8'hFE,0,0,0);
      add(1,1,1,1,0, 1,8'h7F,8'hFE,0,0,0);
      add(0,0,0,0,1, 0,8'h7F,8'hFE,0,0,0);
      // start+stop in COLLECT
      add(0,0,1,0,1, 0,8'h7F,8'hFE,0,1,0);
      add(1,1,0,0,1, 0,8'h7F,8'hFE,1,1,0);
      add(1,1,1,1,1, 0,8'h7F,8'hFE,0,0,0);
      // load in the same cycle the held word is accepted
      add(0,0,1,0,0, 0,8'h7F,8'hFE,0,1,0);
      add_bits(8'hF0, 0, 0, 8'h7F, 8'hFE);
      vecs[$].ev = 1'b1; vecs[$].ew = 8'hF0; vecs[$].ewl = 8'h0F;
      add_bits(8'h0F, 0, 1, 8'hF0, 8'h0F);
      vecs[$].rdy = 1'b1; vecs[$].ew = 8'h0F; vecs[$].ewl = 8'hF0;
      add(1,1,0,0,0, 1,8'h0F,8'hF0,1,1,0);

      #1;
      check("reset_values", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].din, vecs[i].st, vecs[i].sp, vecs[i].rdy);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ew, vecs[i].ewl,
               vecs[i].ec, vecs[i].eb, vecs[i].eo);
      end

      // asynchronous reset mid-word while a word is held
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("async_reset", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("post_reset_idle", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
